axis_pkt_checker: RTL and testbench

//  AXI4-Stream slave sitting directly downstream of the net2axis packet source.

---
 rtl/net2axis_pkg.sv | 28 ++
 rtl/axis_ready_gen.sv | 35 +++
 rtl/axis_pkt_checker.sv | 131 +++++++++++++
 tb/tb_axis_pkt_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/net2axis_pkg.sv
// Shared definitions for the net2axis stream checker: FSM encodings, LFSR taps
// and TKEEP helper functions.
package net2axis_pkg;

  localparam int unsigned KEEP_MAX_W = 64;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IN_PKT = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic int unsigned keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(KEEP_MAX_W); i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

  // True for a non-zero mask of the form 2^n-1 (contiguous from bit 0)
  function automatic logic keep_is_tail(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// TREADY source: constant ready or LFSR-driven backpressure, forced high once
// the checker reaches its terminal state.
module axis_ready_gen
  import net2axis_pkg::*;
#(
  parameter int unsigned C_READY_MODE = 0,
  parameter logic [15:0] C_LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic force_ready,
  output logic ready
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        always_on;

  always_comb begin
    lfsr_next = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    always_on = (C_READY_MODE == 0);
  end

  // ready is registered from the next LFSR value so it tracks lfsr[0]|lfsr[1]
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= C_LFSR_SEED;
      ready <= 1'b0;
    end else begin
      lfsr  <= lfsr_next;
      ready <= force_ready | always_on | lfsr_next[0] | lfsr_next[1];
    end
  end

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink that counts packets/beats/bytes, flags protocol violations
// with sticky bits and raises DONE after a programmed number of packets.
module axis_pkt_checker
  import net2axis_pkg::*;
#(
  parameter int unsigned C_TDATA_WIDTH   = 32,
  parameter int unsigned C_CNT_WIDTH     = 32,
  parameter int unsigned C_EXPECTED_PKTS = 0,
  parameter int unsigned C_READY_MODE    = 0,
  parameter logic [15:0] C_LFSR_SEED     = 16'hACE1
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         S_AXIS_TVALID,
  input  logic [C_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                         S_AXIS_TLAST,
  output logic                         S_AXIS_TREADY,
  output logic [C_CNT_WIDTH-1:0]       PKT_COUNT,
  output logic [C_CNT_WIDTH-1:0]       BEAT_COUNT,
  output logic [C_CNT_WIDTH-1:0]       BYTE_COUNT,
  output logic [C_CNT_WIDTH-1:0]       LAST_PKT_BYTES,
  output logic                         ERR_KEEP,
  output logic                         ERR_STABLE,
  output logic                         ERR_OVERRUN,
  output logic                         DONE
);

  localparam int unsigned KEEP_W = C_TDATA_WIDTH / 8;

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic                     accept;
  logic                     hit_expected;
  logic                     keep_bad;
  logic                     stable_bad;
  logic [C_CNT_WIDTH-1:0]   beat_bytes;
  logic [C_CNT_WIDTH-1:0]   pkt_len;
  logic [C_CNT_WIDTH-1:0]   len_sum;
  logic [C_CNT_WIDTH-1:0]   pkt_next;
  logic                     stall;
  logic [C_TDATA_WIDTH-1:0] stall_data;
  logic [KEEP_W-1:0]        stall_keep;
  logic                     stall_last;

  axis_ready_gen #(
    .C_READY_MODE (C_READY_MODE),
    .C_LFSR_SEED  (C_LFSR_SEED)
  ) u_ready_gen (
    .clk         (ACLK),
    .rst         (ARESET),
    .force_ready (state_next == ST_DONE),
    .ready       (S_AXIS_TREADY)
  );

  // Beat classification and packet accounting
  always_comb begin
    accept       = S_AXIS_TVALID & S_AXIS_TREADY;
    beat_bytes   = C_CNT_WIDTH'(keep_popcount(KEEP_MAX_W'(S_AXIS_TKEEP)));
    len_sum      = ((state == ST_IDLE) ? '0 : pkt_len) + beat_bytes;
    pkt_next     = PKT_COUNT + C_CNT_WIDTH'(1);
    hit_expected = (C_EXPECTED_PKTS != 0) && (pkt_next == C_CNT_WIDTH'(C_EXPECTED_PKTS));
    keep_bad     = S_AXIS_TLAST ? !keep_is_tail(KEEP_MAX_W'(S_AXIS_TKEEP))
                                : (S_AXIS_TKEEP != '1);
    stable_bad   = stall & (!S_AXIS_TVALID || (S_AXIS_TDATA != stall_data) ||
                            (S_AXIS_TKEEP != stall_keep) || (S_AXIS_TLAST != stall_last));
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_IN_PKT: begin
        if (accept) begin
          if (S_AXIS_TLAST) state_next = hit_expected ? ST_DONE : ST_IDLE;
          else              state_next = ST_IN_PKT;
        end
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Statistics, sticky errors and stall snapshot; counters freeze once DONE
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      PKT_COUNT      <= '0;
      BEAT_COUNT     <= '0;
      BYTE_COUNT     <= '0;
      LAST_PKT_BYTES <= '0;
      pkt_len        <= '0;
      ERR_KEEP       <= 1'b0;
      ERR_STABLE     <= 1'b0;
      ERR_OVERRUN    <= 1'b0;
      DONE           <= 1'b0;
      stall          <= 1'b0;
      stall_data     <= '0;
      stall_keep     <= '0;
      stall_last     <= 1'b0;
    end else begin
      stall      <= S_AXIS_TVALID & ~S_AXIS_TREADY;
      stall_data <= S_AXIS_TDATA;
      stall_keep <= S_AXIS_TKEEP;
      stall_last <= S_AXIS_TLAST;
      if (stable_bad) ERR_STABLE <= 1'b1;
      if (accept) begin
        if (state == ST_DONE) begin
          ERR_OVERRUN <= 1'b1;
        end else begin
          BEAT_COUNT <= BEAT_COUNT + C_CNT_WIDTH'(1);
          BYTE_COUNT <= BYTE_COUNT + beat_bytes;
          pkt_len    <= len_sum;
          if (keep_bad) ERR_KEEP <= 1'b1;
          if (S_AXIS_TLAST) begin
            PKT_COUNT      <= pkt_next;
            LAST_PKT_BYTES <= len_sum;
          end
        end
      end
      DONE <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench: three checker instances (mode0/3 pkts, mode1/3 pkts, mode0/1 pkt).
module tb_axis_pkt_checker;

  logic        clk;
  logic        areset [3];
  logic        tvalid [3];
  logic [31:0] tdata  [3];
  logic [3:0]  tkeep  [3];
  logic        tlast  [3];
  logic        tready [3];
  logic [31:0] pkt_count [3];
  logic [31:0] beat_count [3];
  logic [31:0] byte_count [3];
  logic [31:0] last_bytes [3];
  logic        err_keep [3];
  logic        err_stable [3];
  logic        err_overrun [3];
  logic        done [3];

  int pass_cnt = 0;
  int total    = 0;
  int stalls   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axis_pkt_checker #(
      .C_TDATA_WIDTH   (32),
      .C_CNT_WIDTH     (32),
      .C_EXPECTED_PKTS ((g == 2) ? 1 : 3),
      .C_READY_MODE    ((g == 1) ? 1 : 0),
      .C_LFSR_SEED     (16'hACE1)
    ) dut (
      .ACLK           (clk),
      .ARESET         (areset[g]),
      .S_AXIS_TVALID  (tvalid[g]),
      .S_AXIS_TDATA   (tdata[g]),
      .S_AXIS_TKEEP   (tkeep[g]),
      .S_AXIS_TLAST   (tlast[g]),
      .S_AXIS_TREADY  (tready[g]),
      .PKT_COUNT      (pkt_count[g]),
      .BEAT_COUNT     (beat_count[g]),
      .BYTE_COUNT     (byte_count[g]),
      .LAST_PKT_BYTES (last_bytes[g]),
      .ERR_KEEP       (err_keep[g]),
      .ERR_STABLE     (err_stable[g]),
      .ERR_OVERRUN    (err_overrun[g]),
      .DONE           (done[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input int u, input logic [31:0] pk,
                               input logic [31:0] bt, input logic [31:0] by,
                               input logic [31:0] lb, input logic [3:0] flags);
    check({tag, ".pkt"},  pkt_count[u], pk);
    check({tag, ".beat"}, beat_count[u], bt);
    check({tag, ".byte"}, byte_count[u], by);
    check({tag, ".last"}, last_bytes[u], lb);
    check({tag, ".flags(keep,stable,overrun,done)"},
          {err_keep[u], err_stable[u], err_overrun[u], done[u]}, flags);
  endtask

  // Drive one beat just after a falling edge and hold it until accepted
  task automatic send_beat(input int u, input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    tvalid[u] = 1'b1;
    tdata[u]  = d;
    tkeep[u]  = k;
    tlast[u]  = l;
    while (tready[u] !== 1'b1 && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++;
      $error("FAIL handshake_timeout: observed %0d wait cycles expected < 200", n);
    end
    @(negedge clk);
    tvalid[u] = 1'b0;
  endtask

  task automatic send_pkt(input int u, input int nbytes, input logic [31:0] seed);
    int beats;
    beats = (nbytes + 3) / 4;
    for (int i = 0; i < beats; i++) begin
      int rem;
      logic [3:0] k;
      rem = nbytes - 4 * i;
      k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
      send_beat(u, seed + 32'(i), k, (i == beats - 1));
    end
  endtask

  task automatic pulse_reset(input int u);
    areset[u] = 1'b1;
    @(negedge clk);
    areset[u] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      areset[i] = 1'b1;
      tvalid[i] = 1'b0;
      tdata[i]  = '0;
      tkeep[i]  = '0;
      tlast[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      check("reset.tready", tready[i], 0);
      check_outputs("reset", i, 0, 0, 0, 0, 4'b0000);
      areset[i] = 1'b0;
    end
    @(negedge clk);
    check("mode0.tready_after_reset", tready[0], 1);

    // Mode 0: 60B + 64B + 1B -> 15 + 16 + 1 = 32 beats, 125 bytes
    send_pkt(0, 60, 32'h1000);
    check_outputs("t1.p1", 0, 1, 15, 60, 60, 4'b0000);
    send_pkt(0, 64, 32'h2000);
    check_outputs("t1.p2", 0, 2, 31, 124, 64, 4'b0000);
    send_pkt(0, 1, 32'h3000);
    check_outputs("t1.p3", 0, 3, 32, 125, 1, 4'b0001);
    check("t1.tready_in_done", tready[0], 1);

    // Mode 1: same traffic under LFSR backpressure
    stalls = 0;
    send_pkt(1, 60, 32'h1000);
    send_pkt(1, 64, 32'h2000);
    send_pkt(1, 1, 32'h3000);
    check_outputs("t2", 1, 3, 32, 125, 1, 4'b0001);
    check("t2.saw_backpressure", 32'(stalls > 0), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2.tready_held_in_done", tready[1], 1);
    end

    // TKEEP rules
    pulse_reset(1);
    check_outputs("t3.reset", 1, 0, 0, 0, 0, 4'b0000);
    send_beat(1, 32'hA0, 4'b0011, 1'b1);
    check_outputs("t3.legal_tail", 1, 1, 1, 2, 2, 4'b0000);
    send_beat(1, 32'hA1, 4'b0101, 1'b1);
    check_outputs("t3.holey_tail", 1, 2, 2, 4, 2, 4'b1000);
    send_beat(1, 32'hA2, 4'b0111, 1'b0);
    check_outputs("t3.partial_mid", 1, 2, 3, 7, 2, 4'b1000);
    send_beat(1, 32'hA3, 4'b1111, 1'b1);
    check_outputs("t3.close", 1, 3, 4, 11, 7, 4'b1001);

    // Stability: TVALID dropped during a stall
    pulse_reset(1);
    for (int n = 0; n < 200 && tready[1] !== 1'b0; n++) @(negedge clk);
    check("t4a.stall_setup", tready[1], 0);
    tvalid[1] = 1'b1; tdata[1] = 32'h55; tkeep[1] = 4'hF; tlast[1] = 1'b0;
    @(negedge clk);
    check("t4a.no_err_while_held", err_stable[1], 0);
    tvalid[1] = 1'b0;
    @(negedge clk);
    check("t4a.err_stable_drop", err_stable[1], 1);

    // Stability: TDATA changed during a stall
    pulse_reset(1);
    check("t4b.reset_clears", err_stable[1], 0);
    for (int n = 0; n < 200 && tready[1] !== 1'b0; n++) @(negedge clk);
    check("t4b.stall_setup", tready[1], 0);
    tvalid[1] = 1'b1; tdata[1] = 32'h66; tkeep[1] = 4'hF; tlast[1] = 1'b0;
    @(negedge clk);
    check("t4b.no_err_while_held", err_stable[1], 0);
    tdata[1] = 32'h67;
    @(negedge clk);
    check("t4b.err_stable_data", err_stable[1], 1);
    tvalid[1] = 1'b0;

    // DONE after one packet, then overrun
    send_beat(2, 32'hB0, 4'hF, 1'b0);
    check_outputs("t5.first_beat", 2, 0, 1, 4, 0, 4'b0000);
    send_beat(2, 32'hB1, 4'hF, 1'b1);
    check_outputs("t5.done", 2, 1, 2, 8, 8, 4'b0001);
    send_beat(2, 32'hB2, 4'hF, 1'b0);
    check_outputs("t5.overrun", 2, 1, 2, 8, 8, 4'b0011);
    send_beat(2, 32'hB3, 4'h1, 1'b1);
    check_outputs("t5.frozen", 2, 1, 2, 8, 8, 4'b0011);

    // Reset mid-packet, then a clean 64B packet
    pulse_reset(0);
    send_beat(0, 32'hC0, 4'hF, 1'b0);
    send_beat(0, 32'hC1, 4'hF, 1'b0);
    check_outputs("t6.partial", 0, 0, 2, 8, 0, 4'b0000);
    areset[0] = 1'b1;
    @(negedge clk);
    check("t6.tready_in_reset", tready[0], 0);
    check_outputs("t6.reset", 0, 0, 0, 0, 0, 4'b0000);
    areset[0] = 1'b0;
    send_pkt(0, 64, 32'hD000);
    check_outputs("t6.full", 0, 1, 16, 64, 64, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
